// File: rtl/uart_time_report.sv
// ============================================================================
// uart_time_report: streams the RTC time (and date when TIME_REPORT_DATE_EN
// is defined) as one ASCII line into the uart_send handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_time_report #(
    parameter int AUTO_SEC = 1,
    parameter int ACK_WAIT = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic [7:0] day,
    input  logic [7:0] mon,
    input  logic [7:0] year,
    input  logic       rpt_req,
    input  logic       uart_tx_busy,
    output logic       uart_en,
    output logic [7:0] uart_din,
    output logic       rpt_busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

`ifdef TIME_REPORT_DATE_EN
    localparam logic [4:0] c_LAST = 5'd20;
`else
    localparam logic [4:0] c_LAST = 5'd9;
`endif
    localparam int              c_CW      = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
    localparam logic [c_CW-1:0] c_ACK_END = c_CW'(ACK_WAIT - 1);

    state_t          r_state, w_state_nx;
    logic [4:0]      r_idx;
    logic            r_pending;
    logic [7:0]      r_sec_prev;
    logic [7:0]      r_din;
    logic [c_CW-1:0] r_ack_cnt;
    logic [7:0]      r_sec, r_min, r_hour;
    logic            w_trigger, w_take, w_advance, w_load;
    logic [4:0]      w_idx_ld;
    logic [7:0]      w_byte;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
    endfunction

`ifdef TIME_REPORT_DATE_EN
    logic [7:0] r_day, r_mon, r_year;

    function automatic logic [7:0] frame_byte(input logic [4:0] idx,
            input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
            input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
        case (idx)
            5'd0:    return 8'h32;
            5'd1:    return 8'h30;
            5'd2:    return digit(y[7:4]);
            5'd3:    return digit(y[3:0]);
            5'd4:    return 8'h2D;
            5'd5:    return digit(mo[7:4]);
            5'd6:    return digit(mo[3:0]);
            5'd7:    return 8'h2D;
            5'd8:    return digit(d[7:4]);
            5'd9:    return digit(d[3:0]);
            5'd10:   return 8'h20;
            5'd11:   return digit(h[7:4]);
            5'd12:   return digit(h[3:0]);
            5'd13:   return 8'h3A;
            5'd14:   return digit(m[7:4]);
            5'd15:   return digit(m[3:0]);
            5'd16:   return 8'h3A;
            5'd17:   return digit(s[7:4]);
            5'd18:   return digit(s[3:0]);
            5'd19:   return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Byte 0 is loaded in the same edge as the snapshot, so it reads the live fields.
    assign w_byte = w_take ? frame_byte(w_idx_ld, hour, min, sec, day, mon, year)
                           : frame_byte(w_idx_ld, r_hour, r_min, r_sec, r_day, r_mon, r_year);
`else
    logic w_unused_date;
    assign w_unused_date = ^{day, mon, year};

    function automatic logic [7:0] frame_byte(input logic [4:0] idx,
            input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        case (idx)
            5'd0:    return digit(h[7:4]);
            5'd1:    return digit(h[3:0]);
            5'd2:    return 8'h3A;
            5'd3:    return digit(m[7:4]);
            5'd4:    return digit(m[3:0]);
            5'd5:    return 8'h3A;
            5'd6:    return digit(s[7:4]);
            5'd7:    return digit(s[3:0]);
            5'd8:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign w_byte = w_take ? frame_byte(w_idx_ld, hour, min, sec)
                           : frame_byte(w_idx_ld, r_hour, r_min, r_sec);
`endif

    assign w_trigger = rpt_req || ((AUTO_SEC != 0) && (sec != r_sec_prev));
    assign w_take    = (r_state == S_IDLE) && r_pending;
    assign w_advance = (r_state == S_NEXT) && (r_idx != c_LAST);
    assign w_load    = w_take || w_advance;
    assign w_idx_ld  = w_take ? 5'd0 : (r_idx + 5'd1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 5'd0;
            r_pending  <= 1'b0;
            r_sec_prev <= sec;
            r_din      <= 8'h00;
            r_ack_cnt  <= '0;
            r_sec      <= 8'h00;
            r_min      <= 8'h00;
            r_hour     <= 8'h00;
`ifdef TIME_REPORT_DATE_EN
            r_day      <= 8'h00;
            r_mon      <= 8'h00;
            r_year     <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_sec_prev <= sec;
            // A new trigger wins over the clear so nothing arriving at frame start is lost.
            r_pending  <= w_trigger || (r_pending && !w_take);
            if (w_take) begin
                r_idx  <= 5'd0;
                r_sec  <= sec;
                r_min  <= min;
                r_hour <= hour;
`ifdef TIME_REPORT_DATE_EN
                r_day  <= day;
                r_mon  <= mon;
                r_year <= year;
`endif
            end else if (w_advance) begin
                r_idx <= r_idx + 5'd1;
            end
            if (w_load)
                r_din <= w_byte;
            r_ack_cnt <= (r_state == S_ACK) ? r_ack_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        uart_en    = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            S_IDLE:  if (r_pending) w_state_nx = S_LOAD;
            S_LOAD:  w_state_nx = S_SEND;
            S_SEND: begin
                if (!uart_tx_busy) begin
                    uart_en    = 1'b1;
                    w_state_nx = S_ACK;
                end
            end
            S_ACK: begin
                if (uart_tx_busy)
                    w_state_nx = S_DRAIN;
                else if (r_ack_cnt == c_ACK_END)
                    w_state_nx = S_NEXT;
            end
            S_DRAIN: if (!uart_tx_busy) w_state_nx = S_NEXT;
            S_NEXT: begin
                if (r_idx == c_LAST) begin
                    frame_done = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_LOAD;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign uart_din = r_din;
    // Busy drops in the frame_done cycle itself.
    assign rpt_busy = (r_state != S_IDLE) && !frame_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_time_report.sv
// ============================================================================
// tb_uart_time_report: directed + randomized bench with a frame reference model
// and a simple busy-for-N-cycles transmitter model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_time_report;

    localparam int ACK_WAIT = 4;
    localparam int TX_BUSY  = 20;
`ifdef TIME_REPORT_DATE_EN
    localparam int LEN = 21;
`else
    localparam int LEN = 10;
`endif

    logic       sys_clk, sys_rst;
    logic [7:0] sec, min, hour, day, mon, year;
    logic       rpt_req, uart_tx_busy;
    logic       uart_en, rpt_busy, frame_done;
    logic [7:0] uart_din;

    uart_time_report #(.AUTO_SEC(1), .ACK_WAIT(ACK_WAIT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .sec(sec), .min(min), .hour(hour), .day(day), .mon(mon), .year(year),
        .rpt_req(rpt_req), .uart_tx_busy(uart_tx_busy),
        .uart_en(uart_en), .uart_din(uart_din),
        .rpt_busy(rpt_busy), .frame_done(frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int         checks = 0, errors = 0;
    int         cyc = 0, fd_cnt = 0, busy_gaps = 0, tx_left = 0;
    bit         tx_stuck = 0, strobe_seen = 0, in_frame = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int         en_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: busy is updated 1 time unit after the edge, outputs sampled 1 later.
    task automatic tick();
        @(posedge sys_clk);
        cyc++;
        #1;
        if (tx_stuck) begin
            uart_tx_busy = 1'b0;
            strobe_seen  = 0;
            tx_left      = 0;
        end else begin
            if (strobe_seen) begin
                tx_left     = TX_BUSY;
                strobe_seen = 0;
            end
            if (tx_left > 0) begin
                uart_tx_busy = 1'b1;
                tx_left--;
            end else begin
                uart_tx_busy = 1'b0;
            end
        end
        #1;
        if (uart_en) begin
            check("strobe while busy", 32'(uart_tx_busy), 32'd0);
            rx.push_back(uart_din);
            en_cyc.push_back(cyc);
            strobe_seen = 1;
            in_frame    = 1;
        end
        if (frame_done) begin
            fd_cnt++;
            check("rpt_busy at frame_done", 32'(rpt_busy), 32'd0);
            in_frame = 0;
        end else if (in_frame && !rpt_busy) begin
            busy_gaps++;
        end
    endtask

    function automatic logic [7:0] ch(input int v);
        return (v <= 9) ? 8'(48 + v) : 8'h3F;
    endfunction

    function automatic void push_bcd(input logic [7:0] v);
        exp_q.push_back(ch(int'(v) / 16));
        exp_q.push_back(ch(int'(v) % 16));
    endfunction

    function automatic void build_exp(input logic [7:0] h, input logic [7:0] m,
            input logic [7:0] s, input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
        exp_q.delete();
`ifdef TIME_REPORT_DATE_EN
        exp_q.push_back("2"); exp_q.push_back("0"); push_bcd(y);
        exp_q.push_back("-"); push_bcd(mo);
        exp_q.push_back("-"); push_bcd(d);
        exp_q.push_back(" ");
`endif
        push_bcd(h); exp_q.push_back(":"); push_bcd(m); exp_q.push_back(":"); push_bcd(s);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    endfunction

    task automatic wait_frame(input string tag);
        int start = fd_cnt;
        int n = 0;
        while (fd_cnt == start && n < 3000) begin
            tick();
            n++;
        end
        check({tag, " frame_done"}, 32'(fd_cnt - start), 32'd1);
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] h, input logic [7:0] m,
            input logic [7:0] s, input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
        build_exp(h, m, s, d, mo, y);
        check({tag, " length"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(rx[i]), 32'(exp_q[i]));
        check({tag, " rpt_busy gaps"}, 32'(busy_gaps), 32'd0);
        rx.delete();
        en_cyc.delete();
        busy_gaps = 0;
    endtask

    task automatic pulse_req();
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
    endtask

    initial begin
        int n;
        int fd_before;
        sys_rst = 1'b1; rpt_req = 1'b0; uart_tx_busy = 1'b0;
        sec = 8'h00; min = 8'h00; hour = 8'h00; day = 8'h01; mon = 8'h01; year = 8'h00;
        repeat (3) tick();
        check("reset uart_en", 32'(uart_en), 32'd0);
        check("reset uart_din", 32'(uart_din), 32'd0);
        check("reset rpt_busy", 32'(rpt_busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        sys_rst = 1'b0;
        repeat (20) tick();
        check("idle after reset", 32'(rpt_busy) + 32'(rx.size()), 32'd0);

        // Basic report with first-byte latency
        hour = 8'h23; min = 8'h59; sec = 8'h59; year = 8'h26; mon = 8'h04; day = 8'h01;
        build_exp(hour, min, sec, day, mon, year);
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
        check("lat N+1 rpt_busy", 32'(rpt_busy), 32'd0);
        tick();
        check("lat N+2 rpt_busy", 32'(rpt_busy), 32'd1);
        check("lat N+2 uart_din", 32'(uart_din), 32'(exp_q[0]));
        tick();
        check("lat N+3 uart_en", 32'(uart_en), 32'd1);
        wait_frame("basic");
        compare_frame("basic", hour, min, sec, day, mon, year);

        // Invalid BCD minute
        min = 8'h3A;
        pulse_req();
        wait_frame("badbcd");
        compare_frame("badbcd", hour, min, sec, day, mon, year);

        // Randomized fields (invalid nibbles included)
        for (int k = 0; k < 4; k++) begin
            sec = 8'($urandom); min = 8'($urandom); hour = 8'($urandom);
            day = 8'($urandom); mon = 8'($urandom); year = 8'($urandom);
            pulse_req();
            wait_frame("random");
            compare_frame("random", hour, min, sec, day, mon, year);
        end

        // Auto trigger on seconds change, with triggers collapsing during a frame
        sec = 8'h05;
        tick();
        wait_frame("auto05");
        compare_frame("auto05", hour, min, 8'h05, day, mon, year);
        sec = 8'h06;
        n = 0;
        while (rx.size() < 3 && n < 500) begin tick(); n++; end
        check("auto06 in flight", 32'(rx.size() >= 3), 32'd1);
        sec = 8'h07;
        tick();
        pulse_req();
        repeat (3) tick();
        pulse_req();
        wait_frame("auto06");
        compare_frame("auto06", hour, min, 8'h06, day, mon, year);
        wait_frame("auto07");
        compare_frame("auto07", hour, min, 8'h07, day, mon, year);
        fd_before = fd_cnt;
        repeat (600) tick();
        check("no extra frame", 32'(fd_cnt - fd_before) + 32'(rx.size()), 32'd0);

        // Stuck-low busy: each byte advances after the ACK timeout
        tx_stuck = 1;
        pulse_req();
        wait_frame("stuck");
        check("stuck strobes", 32'(en_cyc.size()), 32'(LEN));
        for (int i = 1; i < en_cyc.size(); i++)
            check($sformatf("stuck spacing%0d", i), 32'(en_cyc[i] - en_cyc[i-1]), 32'(ACK_WAIT + 3));
        compare_frame("stuck", hour, min, sec, day, mon, year);
        tx_stuck = 0;
        repeat (5) tick();

        // Mid-frame reset after byte 7
        pulse_req();
        n = 0;
        while (rx.size() < 8 && n < 2000) begin tick(); n++; end
        check("reset byte7 reached", 32'(rx.size()), 32'd8);
        sys_rst = 1'b1;
        in_frame = 0;
        tick();
        check("midrst uart_en", 32'(uart_en), 32'd0);
        check("midrst rpt_busy", 32'(rpt_busy), 32'd0);
        check("midrst uart_din", 32'(uart_din), 32'd0);
        sys_rst = 1'b0;
        fd_before = fd_cnt;
        repeat (400) tick();
        check("midrst no more bytes", 32'(rx.size()), 32'd8);
        check("midrst no frame_done", 32'(fd_cnt - fd_before), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
